// File: rtl/main_memory.sv
// -----------------------------------------------------------------------------
// main_memory
// Block-granular backing store on the memory side of the cache<->memory link.
// Accepts one 128-bit block read or write at a time, waits a fixed LATENCY,
// then pulses mem2cache_ready for exactly one cycle. Read data is registered
// and held until the next read completes.
//
// Ports
//   clk              rising-edge clock
//   r                asynchronous active-high reset (storage is not cleared)
//   cache2mem_valid  request present; must stay high until ready is seen
//   cache2mem_rw     1 = write block, 0 = read block
//   cache2mem_addr   byte address; block index = addr[DEPTH_LOG2+3:4]
//   cache2mem_data   write block data
//   mem2cache_data   registered read block data
//   mem2cache_ready  registered one-cycle completion pulse
// -----------------------------------------------------------------------------
module main_memory #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic         clk,
    input  logic         r,
    input  logic         cache2mem_valid,
    input  logic         cache2mem_rw,
    input  logic [31:0]  cache2mem_addr,
    input  logic [127:0] cache2mem_data,
    output logic [127:0] mem2cache_data,
    output logic         mem2cache_ready
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY    = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    logic [1:0]            state_r;
    logic [7:0]            cnt_r;
    logic                  rw_r;
    logic [DEPTH_LOG2-1:0] idx_r;
    logic [127:0]          wdata_r;
    logic                  finish_s;
    logic                  commit_s;

    // Storage powers up as all-zero and is deliberately outside the reset domain.
    logic [127:0] mem_r [0:DEPTH-1] = '{default: 128'd0};

    // Offset bits and aliasing upper bits are intentionally ignored.
    logic unused_addr_bits_s;
    assign unused_addr_bits_s = ^{cache2mem_addr[31:DEPTH_LOG2+4], cache2mem_addr[3:0]};

    // Final BUSY edge with the request still present completes the access;
    // dropping valid on that same edge aborts it like any earlier BUSY edge.
    always_comb begin
        finish_s = 1'b0;
        commit_s = 1'b0;
        if ((state_r == BUSY) && cache2mem_valid && (cnt_r == 8'd0)) begin
            finish_s = 1'b1;
            commit_s = rw_r;
        end else begin
            finish_s = 1'b0;
            commit_s = 1'b0;
        end
    end

    // Request FSM, latency counter, request latches and registered outputs.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_r         <= IDLE;
            cnt_r           <= 8'd0;
            rw_r            <= 1'b0;
            idx_r           <= '0;
            wdata_r         <= 128'd0;
            mem2cache_data  <= 128'd0;
            mem2cache_ready <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    mem2cache_ready <= 1'b0;
                    if (cache2mem_valid) begin
                        rw_r    <= cache2mem_rw;
                        idx_r   <= cache2mem_addr[DEPTH_LOG2+3:4];
                        wdata_r <= cache2mem_data;
                        cnt_r   <= CNT_LOAD;
                        state_r <= BUSY;
                    end
                end
                BUSY: begin
                    if (!cache2mem_valid) begin
                        // Requester withdrew: drop the access, no write, no pulse.
                        cnt_r   <= 8'd0;
                        state_r <= IDLE;
                    end else if (finish_s) begin
                        mem2cache_ready <= 1'b1;
                        if (!rw_r) begin
                            mem2cache_data <= mem_r[idx_r];
                        end
                        state_r <= RESPOND;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                RESPOND: begin
                    // One idle turn-around cycle; a request seen here waits.
                    mem2cache_ready <= 1'b0;
                    state_r         <= IDLE;
                end
                default: begin
                    mem2cache_ready <= 1'b0;
                    cnt_r           <= 8'd0;
                    state_r         <= IDLE;
                end
            endcase
        end
    end

    // Write commit happens on the ready edge, so a later read sees the new data.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_r[idx_r] <= wdata_r;
        end
    end

endmodule

// File: tb/tb_main_memory.sv
module tb_main_memory;

    logic         clk = 1'b0;
    logic         r = 1'b0;
    logic         valid = 1'b0;
    logic         rw = 1'b0;
    logic [31:0]  addr = 32'd0;
    logic [127:0] wdata = 128'd0;
    logic [127:0] rdata;
    logic         ready;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    main_memory #(.LATENCY(4), .DEPTH_LOG2(10)) dut (
        .clk             (clk),
        .r               (r),
        .cache2mem_valid (valid),
        .cache2mem_rw    (rw),
        .cache2mem_addr  (addr),
        .cache2mem_data  (wdata),
        .mem2cache_data  (rdata),
        .mem2cache_ready (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "timeout");
    end

    // Drive one request; lat = edges from acceptance to ready (-1 if never).
    // With hold=0 valid is dropped at the negedge after the ready edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [127:0] d,
                         input bit hold, output int lat);
        @(negedge clk);
        valid = 1'b1; rw = w; addr = a; wdata = d;
        @(posedge clk); #1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = i;
                break;
            end
        end
        if (!hold) begin
            @(negedge clk);
            valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2 r = 1'b1;
        #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", ready); end
        total++; if (rdata !== 128'd0) begin bad++; $display("FAIL rst_data: got %h want 0", rdata); end
        @(negedge clk); r = 1'b0;
        @(posedge clk); #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_idle_ready: got %b want 0", ready); end
    endtask

    task automatic test_write_read();
        int lat;
        issue(1'b1, 32'h0000_0010, D1, 1'b0, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL wr_lat: got %0d want 4", lat); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL wr_ready_mid: got %b want 1", ready); end
        @(posedge clk); #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL wr_pulse_width: got %b want 0", ready); end
        issue(1'b0, 32'h0000_001C, 128'd0, 1'b0, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL rd_lat: got %0d want 4", lat); end
        total++; if (rdata !== D1) begin bad++; $display("FAIL rd_data: got %h want %h", rdata, D1); end
        @(posedge clk); #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL rd_pulse_width: got %b want 0", ready); end
        total++; if (rdata !== D1) begin bad++; $display("FAIL rd_data_hold: got %h want %h", rdata, D1); end
    endtask

    task automatic test_alias();
        int lat;
        issue(1'b1, 32'h0000_4010, 128'hA5, 1'b0, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL alias_wr_lat: got %0d want 4", lat); end
        total++; if (rdata !== D1) begin bad++; $display("FAIL wr_keeps_data: got %h want %h", rdata, D1); end
        issue(1'b0, 32'h0000_0010, 128'd0, 1'b0, lat);
        total++; if (rdata !== 128'hA5) begin bad++; $display("FAIL alias_rd: got %h want a5", rdata); end
        issue(1'b0, 32'h0000_0020, 128'd0, 1'b0, lat);
        total++; if (rdata !== 128'd0) begin bad++; $display("FAIL untouched_rd: got %h want 0", rdata); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int n;
        issue(1'b1, 32'h0000_0040, 128'h4444, 1'b0, lat);
        issue(1'b1, 32'h0000_0030, 128'h77, 1'b1, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL b2b_first_lat: got %0d want 4", lat); end
        @(negedge clk);
        rw = 1'b0; addr = 32'h0000_0040;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                n = i;
                break;
            end
        end
        total++; if (n !== 6) begin bad++; $display("FAIL b2b_gap: got %0d want 6", n); end
        total++; if (rdata !== 128'h4444) begin bad++; $display("FAIL b2b_alloc_data: got %h want 4444", rdata); end
        @(negedge clk); valid = 1'b0;
        issue(1'b0, 32'h0000_0030, 128'd0, 1'b0, lat);
        total++; if (rdata !== 128'h77) begin bad++; $display("FAIL b2b_wb_data: got %h want 77", rdata); end
    endtask

    task automatic test_abort();
        int lat;
        int seen;
        // Withdraw after two BUSY edges.
        @(negedge clk);
        valid = 1'b1; rw = 1'b1; addr = 32'h0000_0050; wdata = 128'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk); valid = 1'b0;
        seen = 0;
        repeat (10) begin @(posedge clk); #1; if (ready) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_pulse: got %0d want 0", seen); end
        issue(1'b0, 32'h0000_0050, 128'd0, 1'b0, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL abort_rd_lat: got %0d want 4", lat); end
        total++; if (rdata !== 128'd0) begin bad++; $display("FAIL abort_no_write: got %h want 0", rdata); end
        // Withdraw exactly at the edge that would have raised ready.
        @(negedge clk);
        valid = 1'b1; rw = 1'b1; addr = 32'h0000_0060; wdata = 128'hEE;
        repeat (4) @(posedge clk);
        @(negedge clk); valid = 1'b0;
        seen = 0;
        repeat (10) begin @(posedge clk); #1; if (ready) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_last_pulse: got %0d want 0", seen); end
        issue(1'b0, 32'h0000_0060, 128'd0, 1'b0, lat);
        total++; if (rdata !== 128'd0) begin bad++; $display("FAIL abort_last_no_write: got %h want 0", rdata); end
    endtask

    task automatic test_latch();
        int lat;
        @(negedge clk);
        valid = 1'b1; rw = 1'b1; addr = 32'h0000_0070; wdata = 128'h11;
        @(posedge clk); #1;
        @(negedge clk);
        rw = 1'b0; addr = 32'h0000_0080; wdata = 128'h22;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = i;
                break;
            end
        end
        total++; if (lat !== 4) begin bad++; $display("FAIL latch_lat: got %0d want 4", lat); end
        @(negedge clk); valid = 1'b0;
        issue(1'b0, 32'h0000_0070, 128'd0, 1'b0, lat);
        total++; if (rdata !== 128'h11) begin bad++; $display("FAIL latch_wr_data: got %h want 11", rdata); end
        issue(1'b0, 32'h0000_0080, 128'd0, 1'b0, lat);
        total++; if (rdata !== 128'd0) begin bad++; $display("FAIL latch_other_addr: got %h want 0", rdata); end
    endtask

    task automatic test_reset_mid_read();
        int lat;
        int seen;
        issue(1'b0, 32'h0000_4010, 128'd0, 1'b0, lat);
        total++; if (rdata !== 128'hA5) begin bad++; $display("FAIL pre_rst_rd: got %h want a5", rdata); end
        @(negedge clk);
        valid = 1'b1; rw = 1'b0; addr = 32'h0000_0010;
        repeat (3) @(posedge clk);
        #2 r = 1'b1; valid = 1'b0;
        #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b want 0", ready); end
        total++; if (rdata !== 128'd0) begin bad++; $display("FAIL midrst_data: got %h want 0", rdata); end
        @(negedge clk); r = 1'b0;
        seen = 0;
        repeat (10) begin @(posedge clk); #1; if (ready) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_pulse: got %0d want 0", seen); end
        issue(1'b0, 32'h0000_0010, 128'd0, 1'b0, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL postrst_lat: got %0d want 4", lat); end
        total++; if (rdata !== 128'hA5) begin bad++; $display("FAIL postrst_mem_kept: got %h want a5", rdata); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alias();
        test_back_to_back();
        test_abort();
        test_latch();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/main_memory.md
# main_memory

Block-granular main-memory responder that sits on the memory side of the cache↔memory interface, opposite the direct-mapped cache controller. It accepts one 128-bit block read or write request at a time, models a fixed access latency, and then pulses `mem2cache_ready` for one cycle, returning read data on `mem2cache_data`. It serves as the backing store for cache allocate and write-back traffic in both simulation and synthesis builds.

## Interface
- `LATENCY`, default 4: cycles from request acceptance to the `mem2cache_ready` pulse; legal range 1..255.
- `DEPTH_LOG2`, default 10: log2 of the number of 128-bit blocks stored (default 1024 blocks, 16 KiB).
- `clk`  in  1  clock; all state changes on its rising edge.
- `r`  in  1  reset, asynchronous, active-high.
- `cache2mem_valid`  in  1  request present; the cache holds it high, with `rw`, `addr` and `data` stable, until it samples `mem2cache_ready`.
- `cache2mem_rw`  in  1  1 = write block, 0 = read block.
- `cache2mem_addr`  in  32  byte address; `[3:0]` ignored; block index = `[DEPTH_LOG2+3:4]`; upper bits ignored (aliasing).
- `cache2mem_data`  in  128  write block data.
- `mem2cache_data`  out  128  read block data, registered.
- `mem2cache_ready`  out  1  one-cycle completion pulse, registered.

## Operation
- Storage: `mem[0:2**DEPTH_LOG2-1]` of 128 bits, zero-initialised at time 0. It is never cleared by `r`.
- State machine:
  - **IDLE**: when `cache2mem_valid`=1, the edge latches `rw`, the block index and the write data. The counter loads `LATENCY-1`, and the FSM goes to BUSY.
  - **BUSY**: the counter decrements each edge.
    - If `cache2mem_valid`=0 on any edge, the request is aborted: go to IDLE, no write, no ready pulse.
    - When the counter is 0 and `valid`=1, the FSM goes to RESPOND. On that edge a write commits `mem[idx] <= latched data`, or a read loads `mem2cache_data <= mem[idx]`. `mem2cache_ready` is set to 1 on the same edge.
  - **RESPOND**: `mem2cache_ready` is cleared on the next edge, and the FSM goes to IDLE unconditionally. A request present in this cycle is not accepted.
  - **IDLE** (after RESPOND): a new request is accepted on the first edge where `valid`=1.
- Changes to `addr`, `rw` or `data` while BUSY are ignored; the latched copies are used.
- `mem2cache_data` holds its last read value through writes and idle periods. A write response leaves it unchanged.
- Counter width is 8 bits; no wrap occurs because `LATENCY` ≤ 255.

## Timing
- Reset (async): on `r`=1, the FSM goes to IDLE immediately, without waiting for a clock edge.
  - `mem2cache_ready`=0, `mem2cache_data`=0, counter=0.
  - An in-flight request is discarded, with no write.
  - `mem` contents are preserved.
- Latency: if a request is accepted at edge k, `mem2cache_ready` is high from edge k+LATENCY to edge k+LATENCY+1, exactly one cycle.
  - Read data is valid in that same cycle and persists afterwards.
- With `valid` held high continuously, back-to-back requests are accepted at edge k+LATENCY+2 at the earliest (RESPOND→IDLE, then accept). This lets a write-back followed by an allocate proceed with no protocol gap.
- Read-after-write to the same block always returns the new data, because the write commits at its ready edge, before any later acceptance.
- Abort is evaluated on every BUSY edge, including the final one. `valid`=0 at the edge that would assert ready produces no pulse and no write.
- Only one outstanding request is supported; there is no queueing.

## Test plan
- Reset: assert `r` mid-cycle → `mem2cache_ready`=0 and `mem2cache_data`=0 before the next edge; FSM in IDLE.
- Write/read, LATENCY=4: write `addr`=0x00000010, `data`=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, accepted at edge k → ready high only between k+4 and k+5. A subsequent read of 0x0000001C → ready after 4 cycles with the same 128-bit value.
- Aliasing, DEPTH_LOG2=10: write 128'hA5 to 0x00004010, read 0x00000010 → 128'hA5. Read of untouched 0x00000020 → 0.
- Write-back then allocate: `valid` held high, rw=1 at 0x30 (data 128'h77), then rw=0 at 0x40 after the first ready → second ready exactly LATENCY+2 cycles after the first. Returned data is `mem[4]`, and `mem[3]`=128'h77.
- Abort: write 128'hFF to 0x50, drop `valid` two cycles after acceptance → no ready pulse for 10 cycles; a later read of 0x50 returns the previous value (0).
- Reset mid-read: assert `r` at BUSY count 1 → no ready pulse; after release, a read of 0x10 still returns the earlier written data.
